// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns debounced button presses into a short queue of legal
// direction changes and commits one entry per game-step tick.
module snake_dir_ctrl #(
    parameter logic [1:0]  INIT_DIR     = 2'd3,
    parameter int unsigned QUEUE_DEPTH  = 2,
    parameter logic [23:0] REPEAT_DELAY = 24'd12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_i,
    input  logic       tick_i,
    output logic [1:0] dir_o,
    output logic       changed_o,
    output logic       drop_o,
    output logic [2:0] q_cnt_o
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 2) ? 2 : 1;
    localparam int unsigned CNT_W = 24;
    localparam int unsigned DIR_W = 2;

    logic [3:0]       btn_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIR_W-1:0] mem_q [QUEUE_DEPTH];
    logic [DIR_W-1:0] mem_d [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [2:0]       q_cnt_q, q_cnt_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic             changed_q, changed_d;
    logic             drop_q, drop_d;

    logic [3:0]       rise;
    logic             rep_fire;
    logic             req_valid;
    logic [DIR_W-1:0] req_dir;
    logic [DIR_W-1:0] ref_dir;
    logic             full;
    logic             pop;
    logic             push;

    // Fixed priority: up > down > left > right; bit index equals direction code.
    function automatic logic [DIR_W-1:0] prio(input logic [3:0] v);
        if (v[0])      prio = 2'd0;
        else if (v[1]) prio = 2'd1;
        else if (v[2]) prio = 2'd2;
        else           prio = 2'd3;
    endfunction

    // Pointer advance with wrap at the queue depth.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        ptr_next = (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state: edge detect, auto-repeat, acceptance, queue push/pop.
    always_comb begin
        cnt_d     = cnt_q;
        mem_d     = mem_q;
        head_d    = head_q;
        tail_d    = tail_q;
        q_cnt_d   = q_cnt_q;
        dir_d     = dir_q;
        changed_d = 1'b0;
        drop_d    = 1'b0;
        rep_fire  = 1'b0;

        rise = btn_i & ~btn_q;

        if (rise != 4'd0 || btn_i == 4'd0) begin
            cnt_d = '0;
        end else if (REPEAT_DELAY != 24'd0 && cnt_q == REPEAT_DELAY - 24'd1) begin
            rep_fire = 1'b1;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        req_valid = (rise != 4'd0) || rep_fire;
        req_dir   = (rise != 4'd0) ? prio(rise) : prio(btn_i);

        // Reference is the newest queued entry, else the committed direction.
        ref_dir = (q_cnt_q != 3'd0) ? mem_q[tail_q - PTR_W'(1)] : dir_q;
        full    = (q_cnt_q == 3'(QUEUE_DEPTH));
        pop     = tick_i && (q_cnt_q != 3'd0);
        push    = req_valid && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'b01))
                  && (!full || pop);

        if (push) begin
            mem_d[tail_q] = req_dir;
            tail_d        = ptr_next(tail_q);
        end
        if (pop) begin
            dir_d     = mem_q[head_q];
            head_d    = ptr_next(head_q);
            changed_d = 1'b1;
        end
        if (push && !pop)      q_cnt_d = q_cnt_q + 3'd1;
        else if (pop && !push) q_cnt_d = q_cnt_q - 3'd1;

        drop_d = req_valid && !push;
    end

    // State registers; reset is asynchronous and active-high on rst_n.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            btn_q     <= 4'd0;
            cnt_q     <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) mem_q[i] <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            q_cnt_q   <= 3'd0;
            dir_q     <= INIT_DIR;
            changed_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            btn_q     <= btn_i;
            cnt_q     <= cnt_d;
            mem_q     <= mem_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            q_cnt_q   <= q_cnt_d;
            dir_q     <= dir_d;
            changed_q <= changed_d;
            drop_q    <= drop_d;
        end
    end

    assign dir_o     = dir_q;
    assign changed_o = changed_q;
    assign drop_o    = drop_q;
    assign q_cnt_o   = q_cnt_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Testbench for snake_dir_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_snake_dir_ctrl;

    localparam logic [1:0]  P_INIT  = 2'd3;
    localparam int unsigned P_DEPTH = 2;
    localparam int          P_REP   = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_i;
    logic       tick_i;
    logic [1:0] dir_o;
    logic       changed_o;
    logic       drop_o;
    logic [2:0] q_cnt_o;

    int n_cmp;
    int n_err;

    // Behavioural model state
    int     m_dir;
    int     m_q[$];
    logic [3:0] m_prev;
    longint m_cyc;
    longint m_last;
    bit     m_changed;
    bit     m_drop;

    snake_dir_ctrl #(
        .INIT_DIR    (P_INIT),
        .QUEUE_DEPTH (P_DEPTH),
        .REPEAT_DELAY(24'(P_REP))
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_i    (btn_i),
        .tick_i   (tick_i),
        .dir_o    (dir_o),
        .changed_o(changed_o),
        .drop_o   (drop_o),
        .q_cnt_o  (q_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest_bit(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_dir = int'(P_INIT);
        m_q.delete();
        m_prev = 4'd0;
        m_last = 0;
        m_changed = 0;
        m_drop = 0;
    endtask

    // One clock of the game rules applied to the model.
    task automatic model_step(input logic [3:0] b, input logic t);
        logic [3:0] rise;
        int req, refd;
        bit pop, push;
        rise = b & ~m_prev;
        req = -1;
        if (b != 4'd0) begin
            if (rise != 4'd0) begin
                req = lowest_bit(rise);
                m_last = m_cyc;
            end else if (P_REP != 0 && (m_cyc - m_last) == longint'(P_REP)) begin
                req = lowest_bit(b);
                m_last = m_cyc;
            end
        end
        refd = (m_q.size() != 0) ? m_q[$] : m_dir;
        pop  = t && (m_q.size() != 0);
        push = (req >= 0) && (req != refd) && (req != (refd ^ 1))
               && ((m_q.size() < int'(P_DEPTH)) || pop);
        m_drop    = (req >= 0) && !push;
        m_changed = pop;
        if (pop) m_dir = m_q.pop_front();
        if (push) m_q.push_back(req);
        m_prev = b;
        m_cyc++;
    endtask

    task automatic drive(input logic [3:0] b, input logic t);
        @(negedge clk);
        btn_i  = b;
        tick_i = t;
        model_step(b, t);
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset(input logic [3:0] b);
        @(negedge clk);
        btn_i  = b;
        tick_i = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        model_step(b, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] b);
        @(negedge clk);
        rst_n  = 1'b1;
        btn_i  = b;
        tick_i = 1'b0;
        repeat (2) @(negedge clk);
        release_reset(b);
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        btn_i  = 4'd0;
        tick_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dir_o !== P_INIT) begin n_err++; $display("FAIL rst_dir got %0d exp %0d", dir_o, P_INIT); end
        n_cmp++; if (q_cnt_o !== 3'd0) begin n_err++; $display("FAIL rst_qcnt got %0d exp 0", q_cnt_o); end
        n_cmp++; if (changed_o !== 1'b0) begin n_err++; $display("FAIL rst_changed got %b exp 0", changed_o); end
        n_cmp++; if (drop_o !== 1'b0) begin n_err++; $display("FAIL rst_drop got %b exp 0", drop_o); end
        release_reset(4'd0);
    endtask

    task automatic test_basic();
        apply_reset(4'd0);
        drive(4'b0001, 1'b0);
        n_cmp++; if (q_cnt_o !== 3'd1) begin n_err++; $display("FAIL basic_push_q got %0d exp 1", q_cnt_o); end
        n_cmp++; if (drop_o !== 1'b0) begin n_err++; $display("FAIL basic_push_drop got %b exp 0", drop_o); end
        n_cmp++; if (dir_o !== 2'd3) begin n_err++; $display("FAIL basic_nopop_dir got %0d exp 3", dir_o); end
        drive(4'b0000, 1'b1);
        n_cmp++; if (dir_o !== 2'd0) begin n_err++; $display("FAIL basic_pop_dir got %0d exp 0", dir_o); end
        n_cmp++; if (changed_o !== 1'b1) begin n_err++; $display("FAIL basic_changed got %b exp 1", changed_o); end
        n_cmp++; if (q_cnt_o !== 3'd0) begin n_err++; $display("FAIL basic_pop_q got %0d exp 0", q_cnt_o); end
        drive(4'b0000, 1'b0);
        n_cmp++; if (changed_o !== 1'b0) begin n_err++; $display("FAIL basic_changed_end got %b exp 0", changed_o); end
        drive(4'b0000, 1'b1);
        n_cmp++; if (changed_o !== 1'b0 || dir_o !== 2'd0) begin n_err++; $display("FAIL basic_empty_tick got ch=%b dir=%0d exp ch=0 dir=0", changed_o, dir_o); end
    endtask

    task automatic test_reject();
        apply_reset(4'd0);
        drive(4'b0100, 1'b0);
        n_cmp++; if (drop_o !== 1'b1 || q_cnt_o !== 3'd0) begin n_err++; $display("FAIL rej_reversal got drop=%b q=%0d exp drop=1 q=0", drop_o, q_cnt_o); end
        drive(4'b0000, 1'b0);
        n_cmp++; if (drop_o !== 1'b0) begin n_err++; $display("FAIL rej_drop_end got %b exp 0", drop_o); end
        drive(4'b1000, 1'b0);
        n_cmp++; if (drop_o !== 1'b1 || q_cnt_o !== 3'd0) begin n_err++; $display("FAIL rej_repeat got drop=%b q=%0d exp drop=1 q=0", drop_o, q_cnt_o); end
        drive(4'b0000, 1'b0);
    endtask

    task automatic test_fill();
        apply_reset(4'd0);
        drive(4'b0001, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0100, 1'b0);
        n_cmp++; if (q_cnt_o !== 3'd2) begin n_err++; $display("FAIL fill_q2 got %0d exp 2", q_cnt_o); end
        drive(4'b0000, 1'b0);
        drive(4'b0010, 1'b0);
        n_cmp++; if (drop_o !== 1'b1 || q_cnt_o !== 3'd2) begin n_err++; $display("FAIL fill_overflow got drop=%b q=%0d exp drop=1 q=2", drop_o, q_cnt_o); end
        drive(4'b0000, 1'b1);
        n_cmp++; if (dir_o !== 2'd0 || changed_o !== 1'b1) begin n_err++; $display("FAIL fill_pop1 got dir=%0d ch=%b exp dir=0 ch=1", dir_o, changed_o); end
        drive(4'b0000, 1'b1);
        n_cmp++; if (dir_o !== 2'd2 || changed_o !== 1'b1 || q_cnt_o !== 3'd0) begin n_err++; $display("FAIL fill_pop2 got dir=%0d ch=%b q=%0d exp 2 1 0", dir_o, changed_o, q_cnt_o); end
    endtask

    task automatic test_back_to_back();
        apply_reset(4'd0);
        drive(4'b0001, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b0010, 1'b1);
        n_cmp++; if (dir_o !== 2'd0 || q_cnt_o !== 3'd2 || drop_o !== 1'b0) begin n_err++; $display("FAIL b2b_full got dir=%0d q=%0d drop=%b exp 0 2 0", dir_o, q_cnt_o, drop_o); end
        drive(4'b0000, 1'b1);
        n_cmp++; if (dir_o !== 2'd2) begin n_err++; $display("FAIL b2b_pop2 got %0d exp 2", dir_o); end
        drive(4'b0000, 1'b1);
        n_cmp++; if (dir_o !== 2'd1 || q_cnt_o !== 3'd0) begin n_err++; $display("FAIL b2b_pop3 got dir=%0d q=%0d exp 1 0", dir_o, q_cnt_o); end
    endtask

    task automatic test_repeat();
        bit exp_drop;
        apply_reset(4'd0);
        drive(4'b0001, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0001, 1'b0);
        n_cmp++; if (q_cnt_o !== 3'd1 || drop_o !== 1'b0) begin n_err++; $display("FAIL rep_rise got q=%0d drop=%b exp 1 0", q_cnt_o, drop_o); end
        for (int k = 1; k <= 17; k++) begin
            drive(4'b0001, 1'b0);
            exp_drop = (k == P_REP) || (k == 2 * P_REP);
            n_cmp++; if (drop_o !== exp_drop || q_cnt_o !== 3'd1) begin n_err++; $display("FAIL rep_hold k=%0d got drop=%b q=%0d exp drop=%b q=1", k, drop_o, q_cnt_o, exp_drop); end
        end
        drive(4'b0000, 1'b1);
        drive(4'b0100, 1'b0);
        drive(4'b0000, 1'b1);
        drive(4'b0110, 1'b0);
        n_cmp++; if (q_cnt_o !== 3'd1 || drop_o !== 1'b0) begin n_err++; $display("FAIL rep_prio got q=%0d drop=%b exp 1 0", q_cnt_o, drop_o); end
        drive(4'b0000, 1'b1);
        n_cmp++; if (dir_o !== 2'd1 || changed_o !== 1'b1) begin n_err++; $display("FAIL rep_prio_dir got dir=%0d ch=%b exp 1 1", dir_o, changed_o); end
    endtask

    task automatic test_async_reset();
        apply_reset(4'd0);
        drive(4'b0001, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b0000, 1'b1);
        drive(4'b0010, 1'b0);
        n_cmp++; if (q_cnt_o !== 3'd2 || dir_o !== 2'd0) begin n_err++; $display("FAIL arst_pre got q=%0d dir=%0d exp 2 0", q_cnt_o, dir_o); end
        @(negedge clk);
        btn_i = 4'b0001;
        tick_i = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        n_cmp++; if (q_cnt_o !== 3'd0 || dir_o !== P_INIT || changed_o !== 1'b0 || drop_o !== 1'b0) begin
            n_err++; $display("FAIL arst_async got q=%0d dir=%0d ch=%b drop=%b exp 0 %0d 0 0", q_cnt_o, dir_o, changed_o, drop_o, P_INIT);
        end
        repeat (2) @(negedge clk);
        release_reset(4'b0001);
        n_cmp++; if (q_cnt_o !== 3'd1 || drop_o !== 1'b0) begin n_err++; $display("FAIL arst_held got q=%0d drop=%b exp 1 0", q_cnt_o, drop_o); end
        drive(4'b0000, 1'b0);
    endtask

    task automatic test_random();
        int hold;
        logic [3:0] b;
        logic t;
        apply_reset(4'd0);
        b = 4'd0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                hold = int'($urandom_range(1, 20));
            end
            hold--;
            t = ($urandom_range(0, 2) == 0);
            drive(b, t);
            n_cmp++; if (dir_o !== 2'(m_dir)) begin n_err++; $display("FAIL rnd_dir i=%0d got %0d exp %0d", i, dir_o, m_dir); end
            n_cmp++; if (q_cnt_o !== 3'(m_q.size())) begin n_err++; $display("FAIL rnd_qcnt i=%0d got %0d exp %0d", i, q_cnt_o, m_q.size()); end
            n_cmp++; if (changed_o !== m_changed) begin n_err++; $display("FAIL rnd_changed i=%0d got %b exp %b", i, changed_o, m_changed); end
            n_cmp++; if (drop_o !== m_drop) begin n_err++; $display("FAIL rnd_drop i=%0d got %b exp %b", i, drop_o, m_drop); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_cyc = 0;
        model_reset();
        test_reset();
        test_basic();
        test_reject();
        test_fill();
        test_back_to_back();
        test_repeat();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
